// File: rtl/aes_pkg.sv
// Shared constants, FSM encoding and GF(2^8) helpers
// for the iterative AES decrypt path.
package aes_pkg;

    localparam int NR_AES128 = 10;
    localparam int NR_AES192 = 12;
    localparam int NR_AES256 = 14;
    localparam int BLOCK_W   = 128;

    localparam logic [1:0] ENC_IDLE  = 2'd0;
    localparam logic [1:0] ENC_ROUND = 2'd1;
    localparam logic [1:0] ENC_FINAL = 2'd2;
    localparam logic [1:0] ENC_DONE  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = ENC_IDLE,
        ST_ROUND = ENC_ROUND,
        ST_FINAL = ENC_FINAL,
        ST_DONE  = ENC_DONE
    } ctrl_state_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(
        input logic [7:0] a,
        input logic [7:0] b
    );
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ x;
            end
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; zero maps to zero.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    // Inverse affine transform followed by field inversion.
    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] y;
        y = {x[6:0], x[7]}
          ^ {x[4:0], x[7:5]}
          ^ {x[1:0], x[7:2]}
          ^ 8'h05;
        return gf_inv(y);
    endfunction

    // Source byte for InvShiftRows: byte k = row k%4, column k/4;
    // row r rotates right by r columns.
    function automatic int inv_shift_src(input int k);
        int r;
        int c;
        r = k % 4;
        c = k / 4;
        return r + 4 * ((c - r + 4) % 4);
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round:
// InvShiftRows -> InvSubBytes -> AddRoundKey -> optional InvMixColumns.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [BLOCK_W-1:0] state,
    input  logic [BLOCK_W-1:0] round_key,
    input  logic               skip_mix,
    output logic [BLOCK_W-1:0] result
);

    logic [7:0] sb [16];
    logic [7:0] ak [16];
    logic [7:0] mc [16];

    for (genvar k = 0; k < 16; k++) begin : g_byte
        localparam int SRC = inv_shift_src(k);
        assign sb[k] = inv_sbox(state[BLOCK_W-1-8*SRC -: 8]);
        assign ak[k] = sb[k] ^ round_key[BLOCK_W-1-8*k -: 8];
        assign result[BLOCK_W-1-8*k -: 8] = skip_mix ? ak[k] : mc[k];
    end

    for (genvar c = 0; c < 4; c++) begin : g_col
        assign mc[4*c+0] = gf_mul(ak[4*c+0], 8'h0e)
                         ^ gf_mul(ak[4*c+1], 8'h0b)
                         ^ gf_mul(ak[4*c+2], 8'h0d)
                         ^ gf_mul(ak[4*c+3], 8'h09);
        assign mc[4*c+1] = gf_mul(ak[4*c+0], 8'h09)
                         ^ gf_mul(ak[4*c+1], 8'h0e)
                         ^ gf_mul(ak[4*c+2], 8'h0b)
                         ^ gf_mul(ak[4*c+3], 8'h0d);
        assign mc[4*c+2] = gf_mul(ak[4*c+0], 8'h0d)
                         ^ gf_mul(ak[4*c+1], 8'h09)
                         ^ gf_mul(ak[4*c+2], 8'h0e)
                         ^ gf_mul(ak[4*c+3], 8'h0b);
        assign mc[4*c+3] = gf_mul(ak[4*c+0], 8'h0b)
                         ^ gf_mul(ak[4*c+1], 8'h0d)
                         ^ gf_mul(ak[4*c+2], 8'h09)
                         ^ gf_mul(ak[4*c+3], 8'h0e);
    end

endmodule

// File: rtl/aes_inv_cipher_ctrl.sv
// Iterative AES inverse-cipher sequencer: one inverse round per clock,
// round keys fetched by index from the expander's key store.
module aes_inv_cipher_ctrl
    import aes_pkg::*;
#(
    parameter int NR       = NR_AES128,
    parameter int RK_IDX_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                key_valid,
    output logic [RK_IDX_W-1:0] rk_idx,
    input  logic [BLOCK_W-1:0]  rk_data,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BLOCK_W-1:0]  data_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BLOCK_W-1:0]  data_out,
    output logic                busy
);

    ctrl_state_t          st;
    logic [RK_IDX_W-1:0]  cnt;
    logic [BLOCK_W-1:0]   state_reg;
    logic [BLOCK_W-1:0]   round_out;
    logic                 out_valid_q;
    logic                 skip_mix;

    assign in_ready  = (st == ST_IDLE) && key_valid;
    assign busy      = (st != ST_IDLE);
    assign data_out  = state_reg;
    assign out_valid = out_valid_q;
    assign skip_mix  = (st == ST_FINAL);

    // Round-key index is a pure function of state and counter
    always_comb begin
        rk_idx = RK_IDX_W'(NR);
        unique case (1'b1)
            (st == ST_ROUND): rk_idx = cnt;
            (st == ST_FINAL): rk_idx = '0;
            default:          rk_idx = RK_IDX_W'(NR);
        endcase
    end

    aes_inv_round u_round (
        .state     (state_reg),
        .round_key (rk_data),
        .skip_mix  (skip_mix),
        .result    (round_out)
    );

    // Block sequencing: whiten, NR-1 full rounds, final round, hold result
    always_ff @(posedge clk) begin
        if (reset) begin
            st          <= ST_IDLE;
            cnt         <= RK_IDX_W'(NR - 1);
            state_reg   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            unique case (st)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        state_reg <= data_in ^ rk_data;
                        cnt       <= RK_IDX_W'(NR - 1);
                        st        <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    state_reg <= round_out;
                    if (cnt == RK_IDX_W'(1)) begin
                        st <= ST_FINAL;
                    end else begin
                        cnt <= cnt - RK_IDX_W'(1);
                    end
                end
                ST_FINAL: begin
                    state_reg   <= round_out;
                    out_valid_q <= 1'b1;
                    st          <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        st          <= ST_IDLE;
                    end
                end
                default: begin
                    st <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_inv_cipher_ctrl.sv
// Self-checking bench for aes_inv_cipher_ctrl: FIPS-197 vectors,
// random blocks against a byte-level model, and handshake corner cases.
module tb_aes_inv_cipher_ctrl;

    localparam int NR       = 10;
    localparam int RK_IDX_W = 4;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

    typedef struct {
        logic [127:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
    } vec_t;

    logic                clk = 1'b0;
    logic                reset;
    logic                key_valid;
    logic [RK_IDX_W-1:0] rk_idx;
    logic [127:0]        rk_data;
    logic                in_valid;
    logic                in_ready;
    logic [127:0]        data_in;
    logic                out_valid;
    logic                out_ready;
    logic [127:0]        data_out;
    logic                busy;

    logic [127:0] rk_tab [16];
    logic [7:0]   sbox   [256];
    logic [7:0]   isbox  [256];
    vec_t         vt     [8];
    int           n_cmp = 0;
    int           n_bad = 0;

    assign rk_data = rk_tab[rk_idx];

    always #5 clk = ~clk;

    aes_inv_cipher_ctrl #(.NR(NR), .RK_IDX_W(RK_IDX_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .key_valid (key_valid),
        .rk_idx    (rk_idx),
        .rk_data   (rk_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .busy      (busy)
    );

    task automatic check(input string nm, input logic [127:0] act,
                         input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        int p;
        int x;
        p = 0;
        x = int'(a);
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x << 1;
            if ((x & 'h100) != 0) x = x ^ 'h11b;
        end
        return 8'(p);
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    function automatic logic [7:0] getb(input logic [127:0] v, input int k);
        return v[127-8*k -: 8];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] b;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            b = inv;
            sbox[x] = b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
        end
        for (int x = 0; x < 256; x++) isbox[sbox[x]] = 8'(x);
    endtask

    task automatic load_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 16; i++) rk_tab[i] = '0;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
                t[31:24] = t[31:24] ^ rcon;
                rcon = gmul(rcon, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int j = 0; j <= NR; j++)
            rk_tab[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
    endtask

    // Byte-matrix inverse cipher using the currently loaded key schedule.
    function automatic logic [127:0] model_decrypt(input logic [127:0] ct);
        logic [7:0]   s [4][4];
        logic [7:0]   t [4][4];
        logic [127:0] res;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                s[r][c] = getb(ct, 4*c+r) ^ getb(rk_tab[NR], 4*c+r);
        for (int rnd = NR - 1; rnd >= 0; rnd--) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t[(r)][(c + r) % 4] = isbox[s[r][c]];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t[r][c] = t[r][c] ^ getb(rk_tab[rnd], 4*c+r);
            for (int c = 0; c < 4; c++) begin
                if (rnd > 0) begin
                    s[0][c] = gmul(t[0][c], 8'h0e) ^ gmul(t[1][c], 8'h0b)
                            ^ gmul(t[2][c], 8'h0d) ^ gmul(t[3][c], 8'h09);
                    s[1][c] = gmul(t[0][c], 8'h09) ^ gmul(t[1][c], 8'h0e)
                            ^ gmul(t[2][c], 8'h0b) ^ gmul(t[3][c], 8'h0d);
                    s[2][c] = gmul(t[0][c], 8'h0d) ^ gmul(t[1][c], 8'h09)
                            ^ gmul(t[2][c], 8'h0e) ^ gmul(t[3][c], 8'h0b);
                    s[3][c] = gmul(t[0][c], 8'h0b) ^ gmul(t[1][c], 8'h0d)
                            ^ gmul(t[2][c], 8'h09) ^ gmul(t[3][c], 8'h0e);
                end else begin
                    for (int r = 0; r < 4; r++) s[r][c] = t[r][c];
                end
            end
        end
        res = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                res[127-8*(4*c+r) -: 8] = s[r][c];
        return res;
    endfunction

    // Called at the negedge right after acceptance; returns negedge count
    // at which out_valid is first seen (NR+1 when latency is NR edges).
    task automatic wait_done(output int n);
        n = 1;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_block(input logic [127:0] ct, input logic [127:0] exp,
                             input string nm);
        int         n;
        logic [3:0] seen [$];
        logic       seq_ok;
        @(negedge clk);
        check({nm, " idle_rk_idx"}, rk_idx, NR);
        check({nm, " in_ready"}, in_ready, 1'b1);
        in_valid  = 1'b1;
        data_in   = ct;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 50) begin
            seen.push_back(rk_idx);
            @(negedge clk);
            n++;
        end
        check({nm, " latency"}, n - 1, NR);
        seq_ok = (seen.size() == NR);
        for (int k = 0; k < seen.size(); k++)
            if (seen[k] != 4'(NR - 1 - k)) seq_ok = 1'b0;
        check({nm, " rk_seq"}, seq_ok, 1'b1);
        check({nm, " data_out"}, data_out, exp);
        @(negedge clk);
        check({nm, " out_valid_clear"}, out_valid, 1'b0);
        check({nm, " busy_clear"}, busy, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int cyc;
        logic got1;

        reset     = 1'b1;
        key_valid = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        data_in   = '0;
        build_sbox();
        load_key(C1_KEY);

        vt[0].key = C1_KEY; vt[0].ct = C1_CT; vt[0].pt = C1_PT;
        vt[1].key = B_KEY;  vt[1].ct = B_CT;  vt[1].pt = B_PT;
        for (int i = 2; i < 8; i++) begin
            vt[i].key = {$urandom, $urandom, $urandom, $urandom};
            vt[i].ct  = {$urandom, $urandom, $urandom, $urandom};
            load_key(vt[i].key);
            vt[i].pt  = model_decrypt(vt[i].ct);
        end
        load_key(C1_KEY);

        repeat (3) @(negedge clk);
        check("rst out_valid", out_valid, 1'b0);
        check("rst busy", busy, 1'b0);
        check("rst data_out", data_out, '0);
        check("rst rk_idx", rk_idx, NR);
        check("rst in_ready", in_ready, 1'b1);
        key_valid = 1'b0;
        #1;
        check("rst in_ready_kv0", in_ready, 1'b0);
        key_valid = 1'b1;
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            load_key(vt[i].key);
            run_block(vt[i].ct, vt[i].pt, $sformatf("vec%0d", i));
        end

        // Backpressure: DONE holds with in_valid hammering
        load_key(C1_KEY);
        @(negedge clk);
        in_valid  = 1'b1;
        data_in   = C1_CT;
        out_ready = 1'b0;
        @(negedge clk);
        data_in = {$urandom, $urandom, $urandom, $urandom};
        wait_done(n);
        check("bp latency", n - 1, NR);
        check("bp data", data_out, C1_PT);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            data_in = {$urandom, $urandom, $urandom, $urandom};
            check("bp hold_valid", out_valid, 1'b1);
            check("bp hold_data", data_out, C1_PT);
            check("bp in_ready", in_ready, 1'b0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp release out_valid", out_valid, 1'b0);
        check("bp release in_ready", in_ready, 1'b1);
        check("bp release busy", busy, 1'b0);

        // Back-to-back: C.1 then B with in_valid held high
        load_key(C1_KEY);
        @(negedge clk);
        check("b2b first in_ready", in_ready, 1'b1);
        in_valid  = 1'b1;
        data_in   = C1_CT;
        out_ready = 1'b1;
        @(negedge clk);
        cyc     = 1;
        data_in = B_CT;
        got1    = 1'b0;
        while (!in_ready && cyc < 40) begin
            if (out_valid && !got1) begin
                check("b2b first data", data_out, C1_PT);
                got1 = 1'b1;
                load_key(B_KEY);
            end
            @(negedge clk);
            cyc++;
        end
        check("b2b first seen", got1, 1'b1);
        check("b2b spacing", cyc, 12);
        @(negedge clk);
        in_valid = 1'b0;
        wait_done(n);
        check("b2b second latency", n - 1, NR);
        check("b2b second data", data_out, B_PT);
        @(negedge clk);

        // key_valid gating of acceptance
        load_key(C1_KEY);
        @(negedge clk);
        key_valid = 1'b0;
        in_valid  = 1'b1;
        data_in   = C1_CT;
        #1;
        check("kv0 in_ready", in_ready, 1'b0);
        @(negedge clk);
        check("kv0 no accept", busy, 1'b0);
        @(negedge clk);
        check("kv0 still idle", busy, 1'b0);
        key_valid = 1'b1;
        #1;
        check("kv1 in_ready", in_ready, 1'b1);
        @(negedge clk);
        check("kv1 accepted", busy, 1'b1);
        in_valid = 1'b0;
        wait_done(n);
        check("kv1 latency", n - 1, NR);
        check("kv1 data", data_out, C1_PT);
        @(negedge clk);

        // Reset during ROUND
        @(negedge clk);
        in_valid  = 1'b1;
        data_in   = C1_CT;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("rr busy_before", busy, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        check("rr busy", busy, 1'b0);
        check("rr out_valid", out_valid, 1'b0);
        check("rr rk_idx", rk_idx, NR);
        reset = 1'b0;
        run_block(C1_CT, C1_PT, "post_reset");

        // Reset while holding a result in DONE
        @(negedge clk);
        in_valid  = 1'b1;
        data_in   = B_CT;
        out_ready = 1'b0;
        load_key(B_KEY);
        @(negedge clk);
        in_valid = 1'b0;
        wait_done(n);
        check("rd data", data_out, B_PT);
        reset = 1'b1;
        @(negedge clk);
        check("rd out_valid", out_valid, 1'b0);
        check("rd busy", busy, 1'b0);
        reset = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
